// File: rtl/modmul_arbiter.sv
// Round-robin arbiter sharing one Barrett modular multiplier, with credit-protected response FIFO.
// Optional macro MODMUL_ARB_PRIORITY_EN gives requester 0 fixed highest priority.
module modmul_arbiter #(
  parameter int DATA_WIDTH  = 8,
  parameter int NUM_REQ     = 4,
  parameter int ID_WIDTH    = $clog2(NUM_REQ),
  parameter int MUL_LATENCY = 1,
  parameter int RSP_DEPTH   = 4
) (
  input  logic                           clk,
  input  logic                           rst,
  input  logic [NUM_REQ-1:0]             req_valid,
  input  logic [NUM_REQ*DATA_WIDTH-1:0]  req_a,
  input  logic [NUM_REQ*DATA_WIDTH-1:0]  req_b,
  output logic [NUM_REQ-1:0]             req_ready,
  input  logic                           cfg_we,
  input  logic [DATA_WIDTH-1:0]          cfg_modulus,
  output logic                           cfg_ready,
  output logic [DATA_WIDTH-1:0]          mul_a,
  output logic [DATA_WIDTH-1:0]          mul_b,
  output logic [DATA_WIDTH-1:0]          mul_modulus,
  input  logic [DATA_WIDTH-1:0]          mul_result,
  output logic                           rsp_valid,
  input  logic                           rsp_ready,
  output logic [ID_WIDTH-1:0]            rsp_id,
  output logic [DATA_WIDTH-1:0]          rsp_data
);

  localparam int PW = $clog2(RSP_DEPTH);
  localparam int CW = $clog2(RSP_DEPTH + 1);

  logic [ID_WIDTH-1:0]   ptr;
  logic [MUL_LATENCY:0]  tag_v;
  logic [ID_WIDTH-1:0]   tag_id [MUL_LATENCY+1];
  logic [ID_WIDTH-1:0]   fifo_id [RSP_DEPTH];
  logic [DATA_WIDTH-1:0] fifo_data [RSP_DEPTH];
  logic [PW-1:0]         wr_ptr, rd_ptr, head;
  logic [CW-1:0]         fifo_count;
  logic                  issue_ok, grant_any, ptr_adv, cfg_fire, push, pop;
  logic [ID_WIDTH-1:0]   grant_id, ptr_next;
  int unsigned           inflight, idx;

  always_comb begin
    inflight = 0;
    for (int unsigned s = 0; s <= MUL_LATENCY; s++) inflight = inflight + 32'(tag_v[s]);
  end

  assign cfg_ready = !rst && (inflight == 0);
  assign cfg_fire  = cfg_we && cfg_ready;

  // Any cfg_we blocks issue: either the write lands now, or the pipeline must drain for it.
  always_comb begin
    grant_any = 1'b0;
    grant_id  = '0;
    ptr_adv   = 1'b0;
    idx       = 0;
    issue_ok  = !rst && !cfg_we && ((32'(fifo_count) + inflight) < 32'(RSP_DEPTH));
`ifdef MODMUL_ARB_PRIORITY_EN
    if (issue_ok && req_valid[0]) begin
      grant_any = 1'b1;
    end else
`endif
    if (issue_ok) begin
      for (int unsigned k = 0; k < NUM_REQ; k++) begin
        idx = (32'(ptr) + k) % 32'(NUM_REQ);
        if (!grant_any && req_valid[idx]) begin
          grant_any = 1'b1;
          ptr_adv   = 1'b1;
          grant_id  = ID_WIDTH'(idx);
        end
      end
    end
  end

  assign req_ready = grant_any ? (NUM_REQ'(1) << grant_id) : '0;
  assign ptr_next  = (32'(grant_id) + 1 == 32'(NUM_REQ)) ? '0 : grant_id + 1'b1;

  assign push      = tag_v[MUL_LATENCY];
  assign rsp_valid = (fifo_count != '0);
  assign pop       = rsp_valid && rsp_ready;
  // When empty, present the entry just popped so the outputs hold the last head.
  assign head      = rsp_valid ? rd_ptr : rd_ptr - 1'b1;
  assign rsp_id    = fifo_id[head];
  assign rsp_data  = fifo_data[head];

  always_ff @(posedge clk) begin
    if (rst) begin
      ptr         <= '0;
      tag_v       <= '0;
      mul_a       <= '0;
      mul_b       <= '0;
      mul_modulus <= '0;
      wr_ptr      <= '0;
      rd_ptr      <= '0;
      fifo_count  <= '0;
      for (int unsigned s = 0; s <= MUL_LATENCY; s++) tag_id[s] <= '0;
      for (int unsigned e = 0; e < RSP_DEPTH; e++) begin
        fifo_id[e]   <= '0;
        fifo_data[e] <= '0;
      end
    end else begin
      if (cfg_fire) mul_modulus <= cfg_modulus;

      tag_v     <= {tag_v[MUL_LATENCY-1:0], grant_any};
      tag_id[0] <= grant_id;
      for (int unsigned s = 1; s <= MUL_LATENCY; s++) tag_id[s] <= tag_id[s-1];

      if (grant_any) begin
        mul_a <= req_a[32'(grant_id)*DATA_WIDTH +: DATA_WIDTH];
        mul_b <= req_b[32'(grant_id)*DATA_WIDTH +: DATA_WIDTH];
        if (ptr_adv) ptr <= ptr_next;
      end

      if (push) begin
        fifo_id[wr_ptr]   <= tag_id[MUL_LATENCY];
        fifo_data[wr_ptr] <= mul_result;
        wr_ptr            <= wr_ptr + 1'b1;
      end
      if (pop) rd_ptr <= rd_ptr + 1'b1;

      case ({push, pop})
        2'b10:   fifo_count <= fifo_count + 1'b1;
        2'b01:   fifo_count <= fifo_count - 1'b1;
        default: fifo_count <= fifo_count;
      endcase
    end
  end

endmodule

// File: tb/tb_modmul_arbiter.sv
// Directed self-checking bench for modmul_arbiter with a 1-cycle behavioural modular multiplier.
module tb_modmul_arbiter;

  logic        clk = 1'b0;
  logic        rst;
  logic [3:0]  req_valid;
  logic [31:0] req_a, req_b;
  logic [3:0]  req_ready;
  logic        cfg_we;
  logic [7:0]  cfg_modulus;
  logic        cfg_ready;
  logic [7:0]  mul_a, mul_b, mul_modulus, mul_result;
  logic        rsp_valid, rsp_ready;
  logic [1:0]  rsp_id;
  logic [7:0]  rsp_data;

  int tests = 0;
  int fails = 0;
  int cyc = 0;
  bit last_cfg_acc;
  int g_id[$], g_cyc[$], r_id[$], r_data[$], r_cyc[$];

  always #5 clk = ~clk;

  modmul_arbiter #(.DATA_WIDTH(8), .NUM_REQ(4), .MUL_LATENCY(1), .RSP_DEPTH(4)) dut (
    .clk(clk), .rst(rst), .req_valid(req_valid), .req_a(req_a), .req_b(req_b),
    .req_ready(req_ready), .cfg_we(cfg_we), .cfg_modulus(cfg_modulus), .cfg_ready(cfg_ready),
    .mul_a(mul_a), .mul_b(mul_b), .mul_modulus(mul_modulus), .mul_result(mul_result),
    .rsp_valid(rsp_valid), .rsp_ready(rsp_ready), .rsp_id(rsp_id), .rsp_data(rsp_data)
  );

  always @(posedge clk)
    mul_result <= (mul_modulus == 8'd0) ? 8'd0
                : 8'((16'(mul_a) * 16'(mul_b)) % 16'(mul_modulus));

  // One clock: settle inputs, log handshakes, then advance past the posedge to the next negedge.
  task automatic cycle();
    #1;
    last_cfg_acc = cfg_we && cfg_ready;
    if (!rst) begin
      for (int k = 0; k < 4; k++)
        if (req_valid[k] && req_ready[k]) begin
          g_id.push_back(k);
          g_cyc.push_back(cyc);
        end
      if (rsp_valid && rsp_ready) begin
        r_id.push_back(int'(rsp_id));
        r_data.push_back(int'(rsp_data));
        r_cyc.push_back(cyc);
      end
    end
    @(negedge clk);
    cyc++;
  endtask

  task automatic clear_logs();
    g_id.delete(); g_cyc.delete(); r_id.delete(); r_data.delete(); r_cyc.delete();
  endtask

  task automatic set_op(input int i, input logic [7:0] a, input logic [7:0] b);
    req_a[i*8 +: 8] = a;
    req_b[i*8 +: 8] = b;
  endtask

  task automatic apply_reset();
    rst = 1'b1; req_valid = '0; cfg_we = 1'b0; cfg_modulus = '0; rsp_ready = 1'b0;
    cycle();
    cycle();
    rst = 1'b0;
    clear_logs();
  endtask

  task automatic do_cfg(input logic [7:0] m, output bit ok);
    cfg_we = 1'b1; cfg_modulus = m; ok = 1'b0;
    for (int i = 0; i < 20 && !ok; i++) begin
      cycle();
      if (last_cfg_acc) ok = 1'b1;
    end
    cfg_we = 1'b0;
  endtask

  task automatic test_reset();
    rst = 1'b1; req_valid = 4'hF; cfg_we = 1'b0; cfg_modulus = '0; rsp_ready = 1'b0;
    req_a = '0; req_b = '0;
    #1;
    tests++; if (req_ready !== 4'b0) begin fails++; $display("FAIL reset_req_ready got %b exp 0000", req_ready); end
    tests++; if (cfg_ready !== 1'b0) begin fails++; $display("FAIL reset_cfg_ready got %b exp 0", cfg_ready); end
    @(negedge clk); cycle(); cycle();
    req_valid = '0;
    rst = 1'b0;
    #1;
    tests++; if (rsp_valid !== 1'b0) begin fails++; $display("FAIL reset_rsp_valid got %b exp 0", rsp_valid); end
    tests++; if (rsp_id !== 2'd0 || rsp_data !== 8'd0) begin fails++; $display("FAIL reset_rsp_head got id %0d data %0d exp 0/0", rsp_id, rsp_data); end
    tests++; if (mul_a !== 8'd0 || mul_b !== 8'd0 || mul_modulus !== 8'd0) begin fails++; $display("FAIL reset_mul_regs got %0d %0d %0d exp 0 0 0", mul_a, mul_b, mul_modulus); end
    tests++; if (cfg_ready !== 1'b1) begin fails++; $display("FAIL idle_cfg_ready got %b exp 1", cfg_ready); end
    @(negedge clk);
    clear_logs();
  endtask

  task automatic test_single_op();
    bit ok;
    apply_reset();
    do_cfg(8'd251, ok);
    tests++; if (!ok || mul_modulus !== 8'd251) begin fails++; $display("FAIL cfg_251 got ok=%0d mod=%0d exp 1/251", ok, mul_modulus); end
    set_op(2, 8'd200, 8'd100);
    rsp_ready = 1'b1;
    req_valid = 4'b0100;
    for (int i = 0; i < 10 && g_id.size() == 0; i++) cycle();
    req_valid = '0;
    tests++; if (g_id.size() != 1 || mul_a !== 8'd200 || mul_b !== 8'd100) begin fails++; $display("FAIL single_issue got grants=%0d a=%0d b=%0d exp 1/200/100", g_id.size(), mul_a, mul_b); end
    for (int i = 0; i < 10 && r_id.size() == 0; i++) cycle();
    tests++;
    if (r_id.size() != 1 || g_cyc.size() != 1) begin
      fails++; $display("FAIL single_rsp got %0d responses exp 1", r_id.size());
    end else if (r_id[0] != 2 || r_data[0] != 171 || r_cyc[0] - g_cyc[0] != 3) begin
      fails++; $display("FAIL single_rsp got id=%0d data=%0d lat=%0d exp 2/171/3", r_id[0], r_data[0], r_cyc[0] - g_cyc[0]);
    end
  endtask

  task automatic test_round_robin();
    bit ok;
    int exp_id[5]   = '{0, 1, 2, 3, 0};
    int exp_data[5] = '{1, 6, 11, 16, 1};
    apply_reset();
    do_cfg(8'd17, ok);
    for (int i = 0; i < 4; i++) set_op(i, 8'd5, 8'(7 + i));
    rsp_ready = 1'b1;
    req_valid = 4'hF;
    for (int i = 0; i < 30 && g_id.size() < 5; i++) cycle();
    req_valid = '0;
    for (int i = 0; i < 30 && r_id.size() < 5; i++) cycle();
    tests++;
    if (g_id.size() < 5 || r_id.size() < 5) begin
      fails++; $display("FAIL rr_counts got grants=%0d rsps=%0d exp 5/5", g_id.size(), r_id.size());
    end else begin
      for (int k = 0; k < 5; k++) begin
        tests++;
        if (g_id[k] != exp_id[k] || r_id[k] != exp_id[k] || r_data[k] != exp_data[k]) begin
          fails++; $display("FAIL rr_%0d got grant=%0d id=%0d data=%0d exp %0d/%0d/%0d",
                            k, g_id[k], r_id[k], r_data[k], exp_id[k], exp_id[k], exp_data[k]);
        end
      end
    end
  endtask

  task automatic test_backpressure();
    bit ok;
    int exp_id[5]   = '{0, 1, 2, 3, 0};
    int exp_data[5] = '{1, 6, 11, 16, 1};
    apply_reset();
    do_cfg(8'd17, ok);
    for (int i = 0; i < 4; i++) set_op(i, 8'd5, 8'(7 + i));
    rsp_ready = 1'b0;
    req_valid = 4'hF;
    repeat (20) cycle();
    #1;
    tests++; if (g_id.size() != 4) begin fails++; $display("FAIL bp_fill got %0d grants exp 4", g_id.size()); end
    tests++; if (req_ready !== 4'b0 || rsp_valid !== 1'b1) begin fails++; $display("FAIL bp_stall got ready=%b rsp_valid=%b exp 0000/1", req_ready, rsp_valid); end
    @(negedge clk);
    rsp_ready = 1'b1;
    cycle();
    rsp_ready = 1'b0;
    repeat (10) cycle();
    tests++; if (g_id.size() != 5 || r_id.size() != 1) begin fails++; $display("FAIL bp_one_pop got grants=%0d pops=%0d exp 5/1", g_id.size(), r_id.size()); end
    req_valid = '0;
    rsp_ready = 1'b1;
    repeat (15) cycle();
    tests++;
    if (r_id.size() != 5) begin
      fails++; $display("FAIL bp_drain got %0d responses exp 5", r_id.size());
    end else begin
      for (int k = 0; k < 5; k++) begin
        tests++;
        if (r_id[k] != exp_id[k] || r_data[k] != exp_data[k]) begin
          fails++; $display("FAIL bp_rsp_%0d got id=%0d data=%0d exp %0d/%0d", k, r_id[k], r_data[k], exp_id[k], exp_data[k]);
        end
      end
    end
  endtask

  task automatic test_cfg_drain();
    bit ok;
    int blocked_cycles = 0;
    int bad_grants = 0;
    apply_reset();
    do_cfg(8'd17, ok);
    set_op(0, 8'd3, 8'd4);
    set_op(1, 8'd3, 8'd5);
    set_op(3, 8'd10, 8'd10);
    rsp_ready = 1'b1;
    req_valid = 4'b0011;
    for (int i = 0; i < 6 && g_id.size() < 2; i++) begin
      cycle();
      if (g_id.size() > 0) req_valid[g_id[g_id.size()-1]] = 1'b0;
    end
    req_valid = 4'b1000;
    cfg_we = 1'b1;
    cfg_modulus = 8'd13;
    last_cfg_acc = 1'b0;
    for (int i = 0; i < 10 && !last_cfg_acc; i++) begin
      cycle();
      if (!last_cfg_acc) blocked_cycles++;
      if (g_id.size() > 2) bad_grants++;
    end
    cfg_we = 1'b0;
    tests++; if (!last_cfg_acc || blocked_cycles != 2) begin fails++; $display("FAIL cfg_wait got acc=%0d blocked=%0d exp 1/2", last_cfg_acc, blocked_cycles); end
    tests++; if (bad_grants != 0 || g_id.size() != 2) begin fails++; $display("FAIL cfg_no_issue got grants=%0d exp 2", g_id.size()); end
    tests++; if (mul_modulus !== 8'd13) begin fails++; $display("FAIL cfg_13 got %0d exp 13", mul_modulus); end
    for (int i = 0; i < 10 && g_id.size() < 3; i++) cycle();
    req_valid = '0;
    for (int i = 0; i < 10 && r_id.size() < 3; i++) cycle();
    tests++;
    if (r_id.size() != 3) begin
      fails++; $display("FAIL cfg_rsps got %0d exp 3", r_id.size());
    end else if (r_id[0] != 0 || r_data[0] != 12 || r_id[1] != 1 || r_data[1] != 15 || r_id[2] != 3 || r_data[2] != 9) begin
      fails++; $display("FAIL cfg_rsp_vals got %0d:%0d %0d:%0d %0d:%0d exp 0:12 1:15 3:9",
                        r_id[0], r_data[0], r_id[1], r_data[1], r_id[2], r_data[2]);
    end
  endtask

  task automatic test_reset_mid();
    bit ok;
    apply_reset();
    do_cfg(8'd17, ok);
    for (int i = 0; i < 4; i++) set_op(i, 8'd5, 8'(7 + i));
    rsp_ready = 1'b0;
    req_valid = 4'hF;
    for (int i = 0; i < 10 && g_id.size() < 3; i++) cycle();
    req_valid = '0;
    rst = 1'b1;
    cycle();
    rst = 1'b0;
    #1;
    tests++; if (rsp_valid !== 1'b0) begin fails++; $display("FAIL rstmid_rsp_valid got %b exp 0", rsp_valid); end
    tests++; if (mul_modulus !== 8'd0) begin fails++; $display("FAIL rstmid_modulus got %0d exp 0", mul_modulus); end
    @(negedge clk);
    rsp_ready = 1'b1;
    repeat (10) cycle();
    tests++; if (r_id.size() != 0) begin fails++; $display("FAIL rstmid_stale got %0d responses exp 0", r_id.size()); end
    tests++; if (rsp_id !== 2'd0 || rsp_data !== 8'd0) begin fails++; $display("FAIL rstmid_head got id %0d data %0d exp 0/0", rsp_id, rsp_data); end
  endtask

  task automatic test_priority();
    bit ok;
`ifdef MODMUL_ARB_PRIORITY_EN
    int exp_id[4] = '{0, 0, 0, 0};
`else
    int exp_id[4] = '{0, 1, 0, 1};
`endif
    apply_reset();
    do_cfg(8'd17, ok);
    rsp_ready = 1'b1;
    req_valid = 4'b0011;
    for (int i = 0; i < 20 && g_id.size() < 4; i++) cycle();
    req_valid = '0;
    repeat (6) cycle();
    tests++;
    if (g_id.size() < 4) begin
      fails++; $display("FAIL prio_count got %0d grants exp 4", g_id.size());
    end else begin
      for (int k = 0; k < 4; k++) begin
        tests++;
        if (g_id[k] != exp_id[k]) begin fails++; $display("FAIL prio_%0d got %0d exp %0d", k, g_id[k], exp_id[k]); end
      end
    end
  endtask

  initial begin
    test_reset();
    test_single_op();
    test_round_robin();
    test_backpressure();
    test_cfg_drain();
    test_reset_mid();
    test_priority();
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
